// File: rtl/cb_desegment.sv
// Receive-side code block desegmentation.
// Takes the serial code-block stream (bit plus start/last/filling/crc tags), drops filler
// bits, strips and checks the per-block CRC24B, forwards payload bits serially, and reports
// per-block status plus saturating statistics.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cb_valid/cb_data/cb_start/cb_last/cb_filling/cb_crc/cb_size   input bit stream and tags
//   stat_clr                   synchronous clear of the statistics counters
//   tb_data/tb_valid           reassembled transport block bit, one cycle after the data bit
//   cb_done                    one-cycle pulse, block status valid and held until next cb_done
//   cb_crc_ok/cb_has_crc/cb_len_err   block status
//   proto_err                  one-cycle pulse on tag-order violation
//   cb_count/crc_err_count     saturating statistics
module cb_desegment #(
  parameter int unsigned K_PLUS  = 6144,
  parameter int unsigned K_MINUS = 6080,
  parameter int unsigned LEN_W   = 13,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cb_valid,
  input  logic             cb_data,
  input  logic             cb_start,
  input  logic             cb_last,
  input  logic             cb_filling,
  input  logic             cb_crc,
  input  logic             cb_size,
  input  logic             stat_clr,
  output logic             tb_data,
  output logic             tb_valid,
  output logic             cb_done,
  output logic             cb_crc_ok,
  output logic             cb_has_crc,
  output logic             cb_len_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] cb_count,
  output logic [CNT_W-1:0] crc_err_count
);

  localparam logic [23:0]  CRC_POLY = 24'h800063;
  localparam int unsigned  NCRC_W   = 5;
  localparam logic [NCRC_W-1:0] NCRC_FULL = NCRC_W'(24);

  typedef enum logic [1:0] {IDLE, FILL, DATA, PARITY} state_e;

  state_e            state_q, state_d;
  logic [23:0]       crc_q, crc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [NCRC_W-1:0] ncrc_q, ncrc_d;
  logic              size_q, size_d;
  logic              tb_data_q, tb_data_d, tb_valid_q, tb_valid_d;
  logic              done_q, done_d, proto_q, proto_d;
  logic              ok_q, ok_d, has_q, has_d, len_err_q, len_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, crc_err_q, crc_err_d;

  logic              in_blk, is_fill, is_crc, is_data, fb;
  logic [23:0]       crc_base;
  logic [LEN_W-1:0]  len_base, k_sel;
  logic [NCRC_W-1:0] ncrc_base;
  state_e            tag_state;

  // Next-state, datapath and status computation.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    ncrc_d     = ncrc_q;
    size_d     = size_q;
    tb_data_d  = tb_data_q;
    tb_valid_d = 1'b0;
    done_d     = 1'b0;
    proto_d    = 1'b0;
    ok_d       = ok_q;
    has_d      = has_q;
    len_err_d  = len_err_q;
    cnt_d      = cnt_q;
    crc_err_d  = crc_err_q;
    in_blk     = 1'b0;
    fb         = 1'b0;
    crc_base   = crc_q;
    len_base   = len_q;
    ncrc_base  = ncrc_q;
    // Filling wins when both filling and crc are tagged.
    is_fill    = cb_filling;
    is_crc     = cb_crc & ~cb_filling;
    is_data    = ~cb_filling & ~cb_crc;
    tag_state  = is_fill ? FILL : (is_data ? DATA : PARITY);

    if (cb_valid) begin
      if (cb_filling && cb_crc) proto_d = 1'b1;
      if (cb_start) begin
        // A start inside a block abandons the old one without cb_done.
        if (state_q != IDLE) proto_d = 1'b1;
        state_d   = tag_state;
        crc_base  = '0;
        len_base  = '0;
        ncrc_base = '0;
        size_d    = cb_size;
        in_blk    = 1'b1;
      end else if (state_q == IDLE) begin
        proto_d = 1'b1;
      end else begin
        in_blk = 1'b1;
        case (state_q)
          FILL:    state_d = tag_state;
          DATA:    if (is_fill) proto_d = 1'b1; else state_d = tag_state;
          PARITY:  if (!is_crc) proto_d = 1'b1;
          default: ;
        endcase
      end

      if (in_blk) begin
        fb     = crc_base[23] ^ cb_data;
        crc_d  = {crc_base[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
        len_d  = (&len_base) ? len_base : len_base + LEN_W'(1);
        ncrc_d = (is_crc && !(&ncrc_base)) ? ncrc_base + NCRC_W'(1) : ncrc_base;
        if (is_data) begin
          tb_valid_d = 1'b1;
          tb_data_d  = cb_data;
        end
        if (cb_last) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          ok_d      = (crc_d == 24'h0);
          has_d     = (ncrc_d == NCRC_FULL);
          len_err_d = (len_d != k_sel) || ((ncrc_d != '0) && (ncrc_d != NCRC_FULL));
        end
      end
    end

    // Statistics: clear beats a simultaneous increment.
    if (stat_clr) begin
      cnt_d     = '0;
      crc_err_d = '0;
    end else if (done_d) begin
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      if (has_d && !ok_d && !(&crc_err_q)) crc_err_d = crc_err_q + CNT_W'(1);
    end
  end

  assign k_sel = size_d ? LEN_W'(K_PLUS) : LEN_W'(K_MINUS);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      crc_q      <= '0;
      len_q      <= '0;
      ncrc_q     <= '0;
      size_q     <= 1'b0;
      tb_data_q  <= 1'b0;
      tb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      proto_q    <= 1'b0;
      ok_q       <= 1'b0;
      has_q      <= 1'b0;
      len_err_q  <= 1'b0;
      cnt_q      <= '0;
      crc_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      ncrc_q     <= ncrc_d;
      size_q     <= size_d;
      tb_data_q  <= tb_data_d;
      tb_valid_q <= tb_valid_d;
      done_q     <= done_d;
      proto_q    <= proto_d;
      ok_q       <= ok_d;
      has_q      <= has_d;
      len_err_q  <= len_err_d;
      cnt_q      <= cnt_d;
      crc_err_q  <= crc_err_d;
    end
  end

  assign tb_data       = tb_data_q;
  assign tb_valid      = tb_valid_q;
  assign cb_done       = done_q;
  assign proto_err     = proto_q;
  assign cb_crc_ok     = ok_q;
  assign cb_has_crc    = has_q;
  assign cb_len_err    = len_err_q;
  assign cb_count      = cnt_q;
  assign crc_err_count = crc_err_q;

endmodule
